// File: rtl/sobel_ci_driver_if.sv
// Bundle of the window input, custom-instruction call and result output
// signals of the Sobel custom-instruction driver.
// slave  : the driver's view (takes windows, issues calls, produces results).
// master : the environment's view (supplies windows, responds, consumes).
interface sobel_ci_driver_if;
  // Window input handshake
  logic        winValid;
  logic [71:0] window;
  logic        winReady;
  // Custom-instruction call channel
  logic        ciStart;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic [7:0]  ciN;
  logic        ciDone;
  logic [31:0] ciResult;
  // Result output handshake
  logic        outValid;
  logic        outReady;
  logic [31:0] gx;
  logic [31:0] gy;
  logic [7:0]  mag;
  logic        error;

  modport slave (
    input  winValid, window, ciDone, ciResult, outReady,
    output winReady, ciStart, ciValueA, ciValueB, ciN,
           outValid, gx, gy, mag, error
  );

  modport master (
    output winValid, window, ciDone, ciResult, outReady,
    input  winReady, ciStart, ciValueA, ciValueB, ciN,
           outValid, gx, gy, mag, error
  );
endinterface

// File: rtl/sobel_ci_driver.sv
// Sobel 3x3 gradient engine that offloads every multiply to an external
// custom-instruction responder: 12 sequential calls (6 for Gx, 6 for Gy),
// each multiplying one pixel by a small signed coefficient, with the
// products accumulated locally. A per-call wait counter aborts the whole
// window with error=1 if the responder stalls for too long.
module sobel_ci_driver #(
  parameter logic [7:0] customId = 8'h18,
  parameter int         timeout  = 16
) (
  input logic            clock,
  input logic            reset,
  sobel_ci_driver_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [3:0]  LAST_CALL = 4'd11;
  localparam logic [16:0] TMO       = 17'(timeout);

  logic [1:0]  state;
  logic [3:0]  idx;       // current call index 0..11
  logic [15:0] wcnt;      // cycles elapsed since ciStart of current call
  logic [71:0] win_q;     // latched window
  logic [31:0] gx_q, gy_q;
  logic        err_q;

  // Pixel index used by call k (Gx taps first, then Gy taps).
  function automatic logic [3:0] tap_pix(input logic [3:0] k);
    case (k)
      4'd0:    tap_pix = 4'd0;
      4'd1:    tap_pix = 4'd2;
      4'd2:    tap_pix = 4'd3;
      4'd3:    tap_pix = 4'd5;
      4'd4:    tap_pix = 4'd6;
      4'd5:    tap_pix = 4'd8;
      4'd6:    tap_pix = 4'd0;
      4'd7:    tap_pix = 4'd1;
      4'd8:    tap_pix = 4'd2;
      4'd9:    tap_pix = 4'd6;
      4'd10:   tap_pix = 4'd7;
      4'd11:   tap_pix = 4'd8;
      default: tap_pix = 4'd0;
    endcase
  endfunction

  // 3-bit two's complement coefficient used by call k.
  function automatic logic [2:0] tap_coef(input logic [3:0] k);
    case (k)
      4'd0:    tap_coef = 3'b111; // -1
      4'd1:    tap_coef = 3'b001; // +1
      4'd2:    tap_coef = 3'b110; // -2
      4'd3:    tap_coef = 3'b010; // +2
      4'd4:    tap_coef = 3'b111; // -1
      4'd5:    tap_coef = 3'b001; // +1
      4'd6:    tap_coef = 3'b111; // -1
      4'd7:    tap_coef = 3'b110; // -2
      4'd8:    tap_coef = 3'b111; // -1
      4'd9:    tap_coef = 3'b001; // +1
      4'd10:   tap_coef = 3'b010; // +2
      4'd11:   tap_coef = 3'b001; // +1
      default: tap_coef = 3'b000;
    endcase
  endfunction

  logic [7:0] px [9];
  for (genvar k = 0; k < 9; k++) begin : g_px
    assign px[k] = win_q[8*k +: 8];
  end

  logic       calling;
  logic [7:0] pix;
  logic [2:0] coef;
  logic       expire;

  assign calling = (state == S_ISSUE) || (state == S_WAIT);
  assign pix     = px[tap_pix(idx)];
  assign coef    = tap_coef(idx);
  // The call has used up its budget if one more cycle would reach timeout.
  assign expire  = ({1'b0, wcnt} + 17'd1) >= TMO;

  // Call sequencing, accumulation and timeout handling.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      wcnt  <= '0;
      win_q <= '0;
      gx_q  <= '0;
      gy_q  <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.winValid) begin
            win_q <= bus.window;
            gx_q  <= '0;
            gy_q  <= '0;
            err_q <= 1'b0;
            idx   <= '0;
            wcnt  <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (bus.ciDone) begin
            if (idx < 4'd6) gx_q <= gx_q + bus.ciResult;
            else            gy_q <= gy_q + bus.ciResult;
            wcnt <= '0;
            if (idx == LAST_CALL) begin
              state <= S_OUT;
            end else begin
              idx   <= idx + 4'd1;
              state <= S_ISSUE;
            end
          end else if (expire) begin
            // Responder stalled: drop the rest of the window.
            gx_q  <= '0;
            gy_q  <= '0;
            err_q <= 1'b1;
            wcnt  <= '0;
            state <= S_OUT;
          end else begin
            wcnt  <= wcnt + 16'd1;
            state <= S_WAIT;
          end
        end
        S_OUT: begin
          if (bus.outReady) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // |gx| + |gy| at 32 bits, saturated to 8 bits.
  logic [31:0] abs_gx, abs_gy, mag_sum;
  assign abs_gx  = gx_q[31] ? (~gx_q + 32'd1) : gx_q;
  assign abs_gy  = gy_q[31] ? (~gy_q + 32'd1) : gy_q;
  assign mag_sum = abs_gx + abs_gy;

  assign bus.winReady = (state == S_IDLE);
  assign bus.ciStart  = (state == S_ISSUE);
  assign bus.ciValueA = calling ? {24'd0, pix} : 32'd0;
  assign bus.ciValueB = calling ? {29'd0, coef} : 32'd0;
  assign bus.ciN      = customId;
  assign bus.outValid = (state == S_OUT);
  assign bus.gx       = gx_q;
  assign bus.gy       = gy_q;
  assign bus.mag      = (|mag_sum[31:8]) ? 8'd255 : mag_sum[7:0];
  assign bus.error    = err_q;

endmodule
